// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit ALU datapath.
// Steps each accepted op through drive/latch/release phases; every output is a flop.
module alu_sequencer (
    input  logic       clk,
    input  logic       resetBar,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [2:0] req_count,
    input  logic       aIsZero,
    output logic       doSubtract,
    output logic       doCarryIn,
    output logic       doShiftIn,
    output logic       assertBarE,
    output logic       assertBarS,
    output logic       triggerC,
    output logic       triggerS,
    output logic       loadA,
    output logic       busy,
    output logic       done,
    output logic       zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_LSR = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_TST = 3'd7;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] cnt_q, cnt_d;

    logic ready_q, ready_d;
    logic sub_q, sub_d;
    logic cin_q, cin_d;
    logic shin_q, shin_d;
    logic drv_e_n_q, drv_e_n_d;
    logic drv_s_n_q, drv_s_n_d;
    logic trig_c_q, trig_c_d;
    logic trig_s_q, trig_s_d;
    logic load_a_q, load_a_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic zero_q, zero_d;

    logic is_arith;
    logic is_shift;
    logic active;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    cnt_d   = (req_op == OP_LSR || req_op == OP_ROR) ? req_count : 3'd0;
                    state_d = (req_op == OP_TST) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE:   state_d = S_LATCH;
            S_LATCH:   state_d = S_RELEASE;
            S_RELEASE: begin
                if (cnt_q != 3'd0) begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so they appear
        // registered for the whole of that state.
        is_arith = (op_d == OP_ADD) || (op_d == OP_ADC) || (op_d == OP_SUB) ||
                   (op_d == OP_SBC) || (op_d == OP_CMP);
        is_shift = (op_d == OP_LSR) || (op_d == OP_ROR);
        active   = (state_d == S_DRIVE) || (state_d == S_LATCH) || (state_d == S_RELEASE);

        drv_e_n_d = !(active && is_arith);
        drv_s_n_d = !(active && is_shift);
        sub_d     = active && ((op_d == OP_SUB) || (op_d == OP_SBC) || (op_d == OP_CMP));
        cin_d     = active && ((op_d == OP_ADC) || (op_d == OP_SBC));
        shin_d    = active && (op_d == OP_ROR);

        // Strobes only live in LATCH; the drive is still held through RELEASE
        // so the bus stays valid after their falling edge.
        load_a_d  = (state_d == S_LATCH) && (op_d != OP_CMP) && (is_arith || is_shift);
        trig_c_d  = (state_d == S_LATCH) && is_arith;
        trig_s_d  = (state_d == S_LATCH) && is_shift;

        ready_d   = (state_d == S_IDLE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        if (state_d == S_DONE) zero_d = aIsZero;
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            cnt_q     <= 3'd0;
            ready_q   <= 1'b1;
            sub_q     <= 1'b0;
            cin_q     <= 1'b0;
            shin_q    <= 1'b0;
            drv_e_n_q <= 1'b1;
            drv_s_n_q <= 1'b1;
            trig_c_q  <= 1'b0;
            trig_s_q  <= 1'b0;
            load_a_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            sub_q     <= sub_d;
            cin_q     <= cin_d;
            shin_q    <= shin_d;
            drv_e_n_q <= drv_e_n_d;
            drv_s_n_q <= drv_s_n_d;
            trig_c_q  <= trig_c_d;
            trig_s_q  <= trig_s_d;
            load_a_q  <= load_a_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
        end
    end

    assign req_ready  = ready_q;
    assign doSubtract = sub_q;
    assign doCarryIn  = cin_q;
    assign doShiftIn  = shin_q;
    assign assertBarE = drv_e_n_q;
    assign assertBarS = drv_s_n_q;
    assign triggerC   = trig_c_q;
    assign triggerS   = trig_s_q;
    assign loadA      = load_a_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign zero       = zero_q;

    // Both bus drivers enabled at once would short the data bus.
    a_no_contention: assert property (@(posedge clk) disable iff (!resetBar)
        !(!drv_e_n_q && !drv_s_n_q));

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a small ALU/register model reacts to the
// strobes, expectations are queued at issue and checked when done pulses.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       resetBar = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = 3'd0;
    logic [2:0] req_count = 3'd0;
    logic       aIsZero;
    logic       req_ready, doSubtract, doCarryIn, doShiftIn, assertBarE, assertBarS;
    logic       triggerC, triggerS, loadA, busy, done, zero;

    alu_sequencer dut (
        .clk(clk), .resetBar(resetBar), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_count(req_count), .aIsZero(aIsZero),
        .doSubtract(doSubtract), .doCarryIn(doCarryIn), .doShiftIn(doShiftIn),
        .assertBarE(assertBarE), .assertBarS(assertBarS), .triggerC(triggerC),
        .triggerS(triggerS), .loadA(loadA), .busy(busy), .done(done), .zero(zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [11:0] RST_VEC = 12'b1000_0001_1000;
    logic [11:0] obs_vec;
    assign obs_vec = {req_ready, busy, done, zero, loadA, triggerC, triggerS,
                      assertBarE, assertBarS, doSubtract, doCarryIn, doShiftIn};

    // ALU datapath model: A register, B operand, carry and shift flags.
    logic [7:0] a_reg = 8'h00, b_reg = 8'h00, a_pre = 8'h00;
    logic       c_flag = 1'b0, s_flag = 1'b0, c_pre = 1'b0, s_pre = 1'b0;
    logic       preset_req = 1'b0;
    logic [7:0] add_b, shf, bus;
    logic       add_ci;
    logic [8:0] add_sum;
    assign add_b   = doSubtract ? ~b_reg : b_reg;
    assign add_ci  = doCarryIn ? c_flag : doSubtract;
    assign add_sum = {1'b0, a_reg} + {1'b0, add_b} + {8'd0, add_ci};
    assign shf     = {doShiftIn, a_reg[7:1]};
    assign bus     = !assertBarE ? add_sum[7:0] : (!assertBarS ? shf : 8'hzz);
    assign aIsZero = (a_reg == 8'h00);

    logic acc_seen = 1'b0;
    int   acc_cnt = 0, acc_busy = 0;
    always @(posedge clk) begin
        acc_seen <= resetBar && req_valid && req_ready;
        if (resetBar && req_valid && req_ready) begin
            acc_cnt <= acc_cnt + 1;
            if (busy) acc_busy <= acc_busy + 1;
        end
    end

    int   cyc = 0, n_load = 0, n_trc = 0, n_trs = 0, n_dre = 0, n_drs = 0;
    int   done_cnt = 0, d_cyc = 0, d_load = 0, d_trc = 0, d_trs = 0, d_dre = 0, d_drs = 0;
    int   overlap = 0, hold_err = 0;
    logic d_zero = 1'b0, ctl_chg = 1'b0, act_seen = 1'b0;
    logic ld_prev = 1'b0, trc_prev = 1'b0, trs_prev = 1'b0, drv_prev = 1'b0, trig_prev = 1'b0;
    logic [2:0] ctl_ref = 3'd0, ctl_now;
    logic drv;
    int   cyc_n, n_load_n, n_trc_n, n_trs_n, n_dre_n, n_drs_n;
    assign drv      = !assertBarE || !assertBarS;
    assign ctl_now  = {doSubtract, doCarryIn, doShiftIn};
    assign cyc_n    = acc_seen ? 1 : cyc + 1;
    assign n_load_n = (acc_seen ? 0 : n_load) + (loadA ? 1 : 0);
    assign n_trc_n  = (acc_seen ? 0 : n_trc) + (triggerC ? 1 : 0);
    assign n_trs_n  = (acc_seen ? 0 : n_trs) + (triggerS ? 1 : 0);
    assign n_dre_n  = (acc_seen ? 0 : n_dre) + (!assertBarE ? 1 : 0);
    assign n_drs_n  = (acc_seen ? 0 : n_drs) + (!assertBarS ? 1 : 0);

    always @(negedge clk) begin
        if (preset_req) begin
            a_reg <= a_pre; c_flag <= c_pre; s_flag <= s_pre;
        end else begin
            if (loadA && !ld_prev) a_reg <= bus;
            if (triggerC && !trc_prev) c_flag <= add_sum[8];
            if (triggerS && !trs_prev) s_flag <= a_reg[0];
        end
        ld_prev <= loadA; trc_prev <= triggerC; trs_prev <= triggerS;
        cyc <= cyc_n; n_load <= n_load_n; n_trc <= n_trc_n; n_trs <= n_trs_n;
        n_dre <= n_dre_n; n_drs <= n_drs_n;
        if (!assertBarE && !assertBarS) overlap <= overlap + 1;
        if (resetBar && !drv && drv_prev && trig_prev) hold_err <= hold_err + 1;
        drv_prev <= drv; trig_prev <= loadA | triggerC | triggerS;
        if (drv) begin
            if (acc_seen || !act_seen) begin
                ctl_ref <= ctl_now; act_seen <= 1'b1; ctl_chg <= 1'b0;
            end else if (ctl_now != ctl_ref) ctl_chg <= 1'b1;
        end else if (acc_seen) begin
            ctl_ref <= 3'd0; ctl_chg <= 1'b0; act_seen <= 1'b0;
        end
        if (!drv && !acc_seen) act_seen <= 1'b0;
        if (done) begin
            done_cnt <= done_cnt + 1; d_cyc <= cyc_n; d_zero <= zero;
            d_load <= n_load_n; d_trc <= n_trc_n; d_trs <= n_trs_n;
            d_dre <= n_dre_n; d_drs <= n_drs_n;
        end
    end

    typedef struct {
        logic [2:0] op, cnt;
        logic [7:0] a, b;
        logic       c, s;
        logic [7:0] ea;
        logic       ez;
        int         lat, load, trc, trs, dre, drs;
        logic [2:0] ctl;
        logic       ec, es;
    } vec_t;
    vec_t sb[$];
    int   lat_q[$];

    task automatic wait_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic set_model(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        a_pre = a; b_reg = b; c_pre = c; s_pre = s; preset_req = 1'b1;
        wait_neg();
        preset_req = 1'b0;
    endtask

    task automatic issue_op(input logic [2:0] op, input logic [2:0] cnt, output bit ok, output int dstart);
        dstart = done_cnt; ok = 1'b0;
        req_op = op; req_count = cnt; req_valid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            wait_neg();
            if (acc_seen) ok = 1'b1;
        end
        req_valid = 1'b0;
        req_op = op + 3'd3;
        req_count = 3'd7;
    endtask

    task automatic test_reset();
        #3 resetBar = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== RST_VEC) begin
            n_bad++; $display("FAIL reset_async: outputs %b, required %b", obs_vec, RST_VEC);
        end
        wait_neg(); wait_neg();
        n_cmp++;
        if (obs_vec !== RST_VEC) begin
            n_bad++; $display("FAIL reset_held: outputs %b, required %b", obs_vec, RST_VEC);
        end
        resetBar = 1'b1;
        wait_neg();
    endtask

    task automatic test_single_ops();
        vec_t tbl[8];
        vec_t e;
        bit   ok, got;
        int   dstart, ov0, hd0;
        tbl[0] = '{3'd0, 3'd5, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 4, 1, 1, 0, 3, 0, 3'b000, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 3'd0, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 4, 1, 1, 0, 3, 0, 3'b010, 1'b1, 1'b0};
        tbl[2] = '{3'd2, 3'd7, 8'h30, 8'h10, 1'b0, 1'b0, 8'h20, 1'b0, 4, 1, 1, 0, 3, 0, 3'b100, 1'b1, 1'b0};
        tbl[3] = '{3'd3, 3'd0, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 4, 1, 1, 0, 3, 0, 3'b110, 1'b1, 1'b0};
        tbl[4] = '{3'd5, 3'd2, 8'h81, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b0, 10, 3, 0, 3, 0, 9, 3'b001, 1'b0, 1'b0};
        tbl[5] = '{3'd6, 3'd0, 8'h10, 8'h20, 1'b1, 1'b0, 8'h10, 1'b0, 4, 0, 1, 0, 3, 0, 3'b100, 1'b0, 1'b0};
        tbl[6] = '{3'd7, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1, 0, 0, 0, 0, 0, 3'b000, 1'b0, 1'b0};
        tbl[7] = '{3'd4, 3'd7, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 25, 8, 0, 8, 0, 24, 3'b000, 1'b0, 1'b1};
        ov0 = overlap; hd0 = hold_err;
        foreach (tbl[i]) begin
            set_model(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s);
            sb.push_back(tbl[i]);
            issue_op(tbl[i].op, tbl[i].cnt, ok, dstart);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL accept op%0d: not accepted within 10 cycles", tbl[i].op); end
            n_cmp++;
            if (req_ready !== 1'b0) begin
                n_bad++; $display("FAIL ready_drop op%0d: req_ready=%b after accept, required 0", tbl[i].op, req_ready);
            end
            got = (done_cnt != dstart);
            for (int k = 0; k < 40 && !got; k++) begin
                wait_neg();
                got = (done_cnt != dstart);
            end
            e = sb.pop_front();
            n_cmp++;
            if (!got) begin n_bad++; $display("FAIL done_timeout op%0d: no done within 40 cycles", e.op); end
            n_cmp++;
            if (d_cyc !== e.lat) begin n_bad++; $display("FAIL latency op%0d: %0d cycles, required %0d", e.op, d_cyc, e.lat); end
            n_cmp++;
            if (a_reg !== e.ea) begin n_bad++; $display("FAIL a_reg op%0d: 0x%h, required 0x%h", e.op, a_reg, e.ea); end
            n_cmp++;
            if (d_zero !== e.ez) begin n_bad++; $display("FAIL zero op%0d: %b, required %b", e.op, d_zero, e.ez); end
            n_cmp++;
            if ({c_flag, s_flag} !== {e.ec, e.es}) begin
                n_bad++; $display("FAIL flags op%0d: c,s=%b%b, required %b%b", e.op, c_flag, s_flag, e.ec, e.es);
            end
            n_cmp++;
            if (d_load !== e.load || d_trc !== e.trc || d_trs !== e.trs || d_dre !== e.dre || d_drs !== e.drs) begin
                n_bad++;
                $display("FAIL pulses op%0d: loadA/trigC/trigS/drvE/drvS=%0d/%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d/%0d",
                         e.op, d_load, d_trc, d_trs, d_dre, d_drs, e.load, e.trc, e.trs, e.dre, e.drs);
            end
            n_cmp++;
            if (ctl_ref !== e.ctl || ctl_chg !== 1'b0) begin
                n_bad++; $display("FAIL func_ctl op%0d: sub/cin/shin=%b changed=%b, required %b stable", e.op, ctl_ref, ctl_chg, e.ctl);
            end
        end
        n_cmp++;
        if (overlap != ov0 || hold_err != hd0) begin
            n_bad++; $display("FAIL bus_rules: overlap=%0d hold_violations=%0d, required 0/0", overlap - ov0, hold_err - hd0);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops[5]  = '{3'd0, 3'd4, 3'd7, 3'd2, 3'd5};
        logic [2:0] cnts[5] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
        int         lats[5] = '{4, 7, 1, 4, 4};
        int idx = 0, exp_lat, acc0, dn0, ab0, ov0, hd0, last_done;
        set_model(8'h55, 8'h11, 1'b0, 1'b0);
        acc0 = acc_cnt; dn0 = done_cnt; ab0 = acc_busy; ov0 = overlap; hd0 = hold_err;
        last_done = done_cnt;
        req_op = ops[0]; req_count = cnts[0]; req_valid = 1'b1;
        for (int c = 0; c < 20 + 60; c++) begin
            if (c == 20) req_valid = 1'b0;
            if (c >= 20 && lat_q.size() == 0) break;
            wait_neg();
            if (acc_seen) begin
                lat_q.push_back(lats[idx % 5]);
                idx++;
                req_op = ops[idx % 5]; req_count = cnts[idx % 5];
            end
            if (done_cnt != last_done) begin
                last_done = done_cnt;
                n_cmp++;
                if (lat_q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_done: done with no outstanding request");
                end else begin
                    exp_lat = lat_q.pop_front();
                    if (d_cyc !== exp_lat) begin
                        n_bad++; $display("FAIL b2b_latency: %0d cycles, required %0d", d_cyc, exp_lat);
                    end
                end
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (lat_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_drain: %0d ops without done", lat_q.size());
            lat_q.delete();
        end
        n_cmp++;
        if (acc_cnt - acc0 != 4 || done_cnt - dn0 != 4) begin
            n_bad++; $display("FAIL b2b_counts: accepts=%0d dones=%0d, required 4/4", acc_cnt - acc0, done_cnt - dn0);
        end
        n_cmp++;
        if (acc_busy != ab0 || overlap != ov0 || hold_err != hd0) begin
            n_bad++; $display("FAIL b2b_rules: busy_accepts=%0d overlap=%0d hold=%0d, required 0/0/0",
                              acc_busy - ab0, overlap - ov0, hold_err - hd0);
        end
    endtask

    task automatic test_reset_mid_op();
        bit ok, got;
        int dstart, dn0;
        vec_t e;
        set_model(8'h08, 8'h00, 1'b0, 1'b0);
        issue_op(3'd4, 3'd3, ok, dstart);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (loadA === 1'b1) got = 1'b1;
            else wait_neg();
        end
        n_cmp++;
        if (!ok || !got) begin n_bad++; $display("FAIL mid_latch: LSR not accepted or LATCH not reached"); end
        dn0 = done_cnt;
        resetBar = 1'b0;
        #1;
        n_cmp++;
        if (obs_vec !== RST_VEC) begin
            n_bad++; $display("FAIL mid_reset: outputs %b, required %b", obs_vec, RST_VEC);
        end
        wait_neg(); wait_neg();
        resetBar = 1'b1;
        wait_neg();
        n_cmp++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || done_cnt != dn0) begin
            n_bad++; $display("FAIL post_reset_idle: ready=%b busy=%b dones=%0d, required 1/0/0", req_ready, busy, done_cnt - dn0);
        end
        set_model(8'h01, 8'h02, 1'b0, 1'b0);
        sb.push_back('{3'd0, 3'd0, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 4, 1, 1, 0, 3, 0, 3'b000, 1'b0, 1'b0});
        issue_op(3'd0, 3'd0, ok, dstart);
        got = (done_cnt != dstart);
        for (int k = 0; k < 40 && !got; k++) begin
            wait_neg();
            got = (done_cnt != dstart);
        end
        e = sb.pop_front();
        n_cmp++;
        if (!ok || !got || d_cyc !== e.lat || a_reg !== e.ea || d_zero !== e.ez) begin
            n_bad++; $display("FAIL post_reset_add: done=%b latency=%0d a=0x%h zero=%b, required 1/%0d/0x%h/%b",
                              got, d_cyc, a_reg, d_zero, e.lat, e.ea, e.ez);
        end
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller for the 8-bit ALU datapath (adder/subtractor, carry and shift flag flops, zero detect, tri-state bus drivers). It accepts one operation per valid/ready handshake and steps the ALU control lines through drive, latch and release phases. It issues bus-drive enables, flag-flop triggers and the A-register load strobe, repeats shift operations for a programmable count, and reports completion and a captured zero flag.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- resetBar  in  1  asynchronous, active-low reset
- req_valid  in  1  operation request
- req_ready  out  1  high only in IDLE; the request is accepted on the edge where valid & ready
- req_op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 LSR, 5 ROR, 6 CMP, 7 TST
- req_count  in  3  shift iterations minus 1 (LSR/ROR only; ignored otherwise)
- aIsZero  in  1  from ALU zero detect (A-reg == 0)
- doSubtract, doCarryIn, doShiftIn  out  1 each  ALU function controls
- assertBarE  out  1  active-low adder-output bus drive
- assertBarS  out  1  active-low shifter-output bus drive
- triggerC, triggerS  out  1 each  rising-edge clocks for the carry/shift flag flops
- loadA  out  1  A-register load pulse (external reg captures the bus on its rising edge)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in DONE
- zero  out  1  registered copy of aIsZero, updated in DONE

## Operation
- States: IDLE, DRIVE, LATCH, RELEASE, DONE. All outputs are registered.
- Op decode is latched at acceptance and held until DONE. Input changes after acceptance are ignored.
  - ADD: sub=0, cin=0
  - ADC: sub=0, carryIn=1
  - SUB: sub=1, carryIn=0
  - SBC: sub=1, carryIn=1
  - CMP: same as SUB, but loadA is never pulsed
  - LSR: shiftIn=0
  - ROR: shiftIn=1
  - TST: no datapath activity
- IDLE:
  - On accept of TST, go to DONE.
  - On accept of any other op, go to DRIVE. The iteration counter loads req_count for LSR/ROR and 0 otherwise.
- DRIVE:
  - Arithmetic ops: assertBarE=0. Shift ops: assertBarS=0.
  - Function controls are valid. Go to LATCH.
- LATCH:
  - The same drive stays asserted.
  - loadA=1, except for CMP.
  - Arithmetic ops: triggerC=1. Shift ops: triggerS=1.
  - Go to RELEASE.
- RELEASE:
  - Drive stays asserted. loadA, triggerC and triggerS return to 0.
  - If counter≠0: decrement and go to DRIVE. Otherwise go to DONE.
- DONE: done=1, zero<=aIsZero, drives deasserted, function controls 0. Go to IDLE.
- The drive enable is never released in the same cycle that a trigger or loadA falls. This gives hold time on dbus.
- assertBarE and assertBarS are never low simultaneously. Bus contention is a design error.

## Timing
- Reset values:
  - State IDLE; req_ready=1; busy=0; done=0; zero=0; loadA=0.
  - triggerC=0, triggerS=0; assertBarE=1, assertBarS=1.
  - doSubtract=0, doCarryIn=0, doShiftIn=0.
- Reset asserted mid-operation forces the reset values immediately (asynchronously). Any partial A-reg/flag update already made stands.
- Latency from the accept edge to the done pulse:
  - arithmetic/CMP: 4 cycles
  - shift: 3·(req_count+1)+1 cycles
  - TST: 1 cycle
- req_ready falls on the cycle after acceptance. A back-to-back request is accepted at the earliest on the cycle after DONE (IDLE).
- A request held during busy is neither lost nor double-accepted. It waits until IDLE.
- Function controls are stable from DRIVE through the last RELEASE of the operation, including across shift iterations.
- triggerC, triggerS and loadA are exactly 1 cycle wide per iteration.
- The counter wraps never: count 7 gives exactly 8 iterations.

## Test plan
- Reset, then ADD (A=0x12, B=0x34).
  - Required: ready drops, assertBarE=0 for 3 cycles, one loadA and one triggerC pulse, done 4 cycles after accept.
  - Model A-reg = 0x46; zero=0.
- SBC with carry flag=1, A=0x05, B=0x05.
  - Required: doSubtract=1 and doCarryIn=1 throughout, A=0x00 afterwards, done asserts with zero=1.
- ROR with req_count=2, A=0x81, shift flag=1.
  - Required: 3 triggerS pulses and 3 loadA pulses, assertBarE stays high, done at 10 cycles.
  - Model A=0xF0, shift flag=0.
- CMP A=0x10, B=0x20: triggerC pulses, loadA never pulses, A stays 0x10. TST with A=0: done 1 cycle after accept, zero=1.
- Hold req_valid high with alternating ops for 20 cycles. Required: accepts only in IDLE, no bus-enable overlap, no missed or duplicate done.
- Assert resetBar low during the LATCH state of a 4-iteration LSR. Required: all outputs at reset values in the same cycle; after release, ready=1 and the next op runs normally.
